l2_intl_xbar: RTL and testbench

Word-interleaved crossbar directly upstream of the interleaved L2 SRAM banks. It takes NB_MASTERS TCDM-style master ports (FC, uDMA, debug, AXI bridge), decodes the bank from the byte address and arbitrates per bank. It forwards a compacted per-bank address and routes each bank's 1-cycle read response back to the master that issued it.

---
 rtl/l2_xbar_pkg.sv | 39 +++
 rtl/l2_xbar_arbiter.sv | 71 +++++++
 rtl/l2_intl_xbar.sv | 137 +++++++++++++
 tb/tb_l2_intl_xbar.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_xbar_pkg.sv
// l2_xbar_pkg: shared types and helpers for the interleaved L2 crossbar.
// Optional feature macro used by this slice: L2_XBAR_RR_ARB_EN (round-robin bank arbitration).
package l2_xbar_pkg;

  // Byte base of the interleaved TCDM/L2 region in the SoC memory map
  localparam logic [31:0] SOC_MEM_MAP_TCDM_START_ADDR = 32'h1C01_0000;

  // Index types are sized for the largest supported crossbar (64 banks, 16 masters)
  localparam int unsigned L2_BS_MAX = 6;
  localparam int unsigned L2_MS_MAX = 4;

  typedef logic [L2_BS_MAX-1:0] bank_idx_t;
  typedef logic [L2_MS_MAX-1:0] master_idx_t;

  // Outstanding response tag for one bank: which master owns next cycle's rvalid
  typedef struct packed {
    logic        valid;
    master_idx_t idx;
  } resp_q_t;

  // Word-interleaved bank select: low word-address bits of the region offset
  function automatic bank_idx_t l2_bank_of(input logic [31:0] add,
                                           input logic [31:0] base,
                                           input int unsigned nbBanks);
    logic [31:0] wordOff;
    wordOff = (add - base) >> 2;
    return bank_idx_t'(wordOff & (nbBanks - 1));
  endfunction

  // Bank-local byte address: drop the bank-select bits and re-base
  function automatic logic [31:0] l2_compact_addr(input logic [31:0] add,
                                                  input logic [31:0] base,
                                                  input int unsigned bs);
    logic [31:0] off;
    off = add - base;
    return base + ((off >> (2 + bs)) << 2);
  endfunction

endpackage

// File: rtl/l2_xbar_arbiter.sv
// l2_xbar_arbiter: per-bank arbiter, one-hot grant plus winner index.
// With L2_XBAR_RR_ARB_EN defined it keeps a round-robin pointer; otherwise
// the lowest requesting master index wins (fixed priority, no state).
module l2_xbar_arbiter #(
  parameter int unsigned NB_MASTERS = 4,
  parameter int unsigned MS         = $clog2(NB_MASTERS)
) (
`ifdef L2_XBAR_RR_ARB_EN
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_bgnt,
`endif
  input  logic [NB_MASTERS-1:0] i_req,
  output logic [NB_MASTERS-1:0] o_gnt,
  output logic [MS-1:0]         o_idx
);

`ifdef L2_XBAR_RR_ARB_EN
  logic [MS-1:0] r_ptr;
  logic [MS-1:0] w_nextPtr;
  logic [MS-1:0] w_lowIdx;
  logic [MS-1:0] w_highIdx;
  logic          w_highFound;

  // Winner is the first requester at or above the pointer, wrapping to the lowest requester
  always_comb begin
    w_lowIdx    = '0;
    w_highIdx   = '0;
    w_highFound = 1'b0;
    for (int j = int'(NB_MASTERS) - 1; j >= 0; j--) begin
      if (i_req[j]) begin
        w_lowIdx = MS'(j);
        if (MS'(j) >= r_ptr) begin
          w_highIdx   = MS'(j);
          w_highFound = 1'b1;
        end
      end
    end
    o_idx     = w_highFound ? w_highIdx : w_lowIdx;
    w_nextPtr = (o_idx == MS'(NB_MASTERS - 1)) ? '0 : o_idx + MS'(1);
  end

  // Pointer advances past the winner only when the bank actually accepts the transfer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if ((|i_req) && i_bgnt) begin
      r_ptr <= w_nextPtr;
    end
  end
`else
  // Fixed priority: lowest requesting index wins
  always_comb begin
    o_idx = '0;
    for (int j = int'(NB_MASTERS) - 1; j >= 0; j--) begin
      if (i_req[j]) begin
        o_idx = MS'(j);
      end
    end
  end
`endif

  // Expand the winner index into a one-hot grant, empty when nobody requests
  always_comb begin
    o_gnt = '0;
    for (int j = 0; j < int'(NB_MASTERS); j++) begin
      o_gnt[j] = (|i_req) && (o_idx == MS'(j));
    end
  end

endmodule

// File: rtl/l2_intl_xbar.sv
// l2_intl_xbar: word-interleaved crossbar in front of the L2 SRAM banks.
// Decodes bank from byte address, arbitrates per bank, compacts the address
// and routes each bank's 1-cycle response back to its requester.
// Optional macro: L2_XBAR_RR_ARB_EN selects round-robin instead of fixed priority.
module l2_intl_xbar
  import l2_xbar_pkg::*;
#(
  parameter int unsigned NB_MASTERS = 4,
  parameter int unsigned NB_BANKS   = 4,
  parameter logic [31:0] BASE_ADDR  = SOC_MEM_MAP_TCDM_START_ADDR
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NB_MASTERS-1:0]    m_req_i,
  input  logic [NB_MASTERS*32-1:0] m_add_i,
  input  logic [NB_MASTERS-1:0]    m_wen_i,
  input  logic [NB_MASTERS*32-1:0] m_wdata_i,
  input  logic [NB_MASTERS*4-1:0]  m_be_i,
  output logic [NB_MASTERS-1:0]    m_gnt_o,
  output logic [NB_MASTERS-1:0]    m_rvalid_o,
  output logic [NB_MASTERS*32-1:0] m_rdata_o,
  output logic [NB_BANKS-1:0]      b_req_o,
  output logic [NB_BANKS*32-1:0]   b_add_o,
  output logic [NB_BANKS-1:0]      b_wen_o,
  output logic [NB_BANKS*32-1:0]   b_wdata_o,
  output logic [NB_BANKS*4-1:0]    b_be_o,
  input  logic [NB_BANKS-1:0]      b_gnt_i,
  input  logic [NB_BANKS-1:0]      b_rvalid_i,
  input  logic [NB_BANKS*32-1:0]   b_rdata_i
);

  localparam int unsigned BS = $clog2(NB_BANKS);
  localparam int unsigned MS = $clog2(NB_MASTERS);

  bank_idx_t             w_mBank   [NB_MASTERS];
  logic [31:0]           w_mAddr   [NB_MASTERS];
  logic [NB_MASTERS-1:0] w_bankReq [NB_BANKS];
  logic [NB_MASTERS-1:0] w_winOh   [NB_BANKS];
  logic [MS-1:0]         w_winIdx  [NB_BANKS];
  resp_q_t               r_resp    [NB_BANKS];

  // Per-master target bank and compacted bank-local address
  always_comb begin
    for (int m = 0; m < int'(NB_MASTERS); m++) begin
      w_mBank[m] = l2_bank_of(m_add_i[m*32 +: 32], BASE_ADDR, NB_BANKS);
      w_mAddr[m] = l2_compact_addr(m_add_i[m*32 +: 32], BASE_ADDR, BS);
    end
  end

  // Request matrix: which masters are asking for each bank this cycle
  always_comb begin
    for (int b = 0; b < int'(NB_BANKS); b++) begin
      w_bankReq[b] = '0;
      for (int m = 0; m < int'(NB_MASTERS); m++) begin
        w_bankReq[b][m] = m_req_i[m] && (w_mBank[m] == bank_idx_t'(b));
      end
    end
  end

  for (genvar gb = 0; gb < int'(NB_BANKS); gb++) begin : g_bank
    l2_xbar_arbiter #(
      .NB_MASTERS(NB_MASTERS),
      .MS        (MS)
    ) u_arb (
`ifdef L2_XBAR_RR_ARB_EN
      .i_clk (clk_i),
      .i_rst (rst_i),
      .i_bgnt(b_gnt_i[gb]),
`endif
      .i_req (w_bankReq[gb]),
      .o_gnt (w_winOh[gb]),
      .o_idx (w_winIdx[gb])
    );
  end

  // Bank side: forward the winner's transfer, all-zero when the bank is idle
  always_comb begin
    b_req_o   = '0;
    b_add_o   = '0;
    b_wen_o   = '0;
    b_wdata_o = '0;
    b_be_o    = '0;
    for (int b = 0; b < int'(NB_BANKS); b++) begin
      b_req_o[b] = (!rst_i) && (|w_bankReq[b]);
      for (int m = 0; m < int'(NB_MASTERS); m++) begin
        if (w_winOh[b][m]) begin
          b_add_o[b*32 +: 32]   = w_mAddr[m];
          b_wen_o[b]            = m_wen_i[m];
          b_wdata_o[b*32 +: 32] = m_wdata_i[m*32 +: 32];
          b_be_o[b*4 +: 4]      = m_be_i[m*4 +: 4];
        end
      end
    end
  end

  // Master grant: won arbitration on its bank and the bank accepted it
  always_comb begin
    m_gnt_o = '0;
    for (int m = 0; m < int'(NB_MASTERS); m++) begin
      for (int b = 0; b < int'(NB_BANKS); b++) begin
        if ((!rst_i) && w_winOh[b][m] && b_gnt_i[b]) begin
          m_gnt_o[m] = 1'b1;
        end
      end
    end
  end

  // Remember who owns each bank's response; tag lives exactly one cycle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < int'(NB_BANKS); b++) begin
        r_resp[b] <= '0;
      end
    end else begin
      for (int b = 0; b < int'(NB_BANKS); b++) begin
        r_resp[b].valid <= b_req_o[b] && b_gnt_i[b];
        r_resp[b].idx   <= master_idx_t'(w_winIdx[b]);
      end
    end
  end

  // Response return: OR-mux bank data to the tagged master, untagged rvalids dropped
  always_comb begin
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    for (int m = 0; m < int'(NB_MASTERS); m++) begin
      for (int b = 0; b < int'(NB_BANKS); b++) begin
        if ((!rst_i) && b_rvalid_i[b] && r_resp[b].valid &&
            (r_resp[b].idx == master_idx_t'(m))) begin
          m_rvalid_o[m]         = 1'b1;
          m_rdata_o[m*32 +: 32] = m_rdata_o[m*32 +: 32] | b_rdata_i[b*32 +: 32];
        end
      end
    end
  end

endmodule

// File: tb/tb_l2_intl_xbar.sv
// tb_l2_intl_xbar: directed self-checking bench for l2_intl_xbar (4 masters, 4 banks).
// Expectations for the contention case follow L2_XBAR_RR_ARB_EN when defined.
module tb_l2_intl_xbar;

  localparam logic [31:0] BASE = 32'h1C01_0000;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [3:0]   m_req_i;
  logic [127:0] m_add_i;
  logic [3:0]   m_wen_i;
  logic [127:0] m_wdata_i;
  logic [15:0]  m_be_i;
  logic [3:0]   m_gnt_o;
  logic [3:0]   m_rvalid_o;
  logic [127:0] m_rdata_o;
  logic [3:0]   b_req_o;
  logic [127:0] b_add_o;
  logic [3:0]   b_wen_o;
  logic [127:0] b_wdata_o;
  logic [15:0]  b_be_o;
  logic [3:0]   b_gnt_i;
  logic [3:0]   b_rvalid_i;
  logic [127:0] b_rdata_i;

  int checks = 0;
  int errors = 0;

  // Free-running 100 MHz clock
  always #5 clk_i = ~clk_i;

  l2_intl_xbar #(
    .NB_MASTERS(4),
    .NB_BANKS  (4),
    .BASE_ADDR (BASE)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .m_req_i   (m_req_i),
    .m_add_i   (m_add_i),
    .m_wen_i   (m_wen_i),
    .m_wdata_i (m_wdata_i),
    .m_be_i    (m_be_i),
    .m_gnt_o   (m_gnt_o),
    .m_rvalid_o(m_rvalid_o),
    .m_rdata_o (m_rdata_o),
    .b_req_o   (b_req_o),
    .b_add_o   (b_add_o),
    .b_wen_o   (b_wen_o),
    .b_wdata_o (b_wdata_o),
    .b_be_o    (b_be_o),
    .b_gnt_i   (b_gnt_i),
    .b_rvalid_i(b_rvalid_i),
    .b_rdata_i (b_rdata_i)
  );

  // Advance to just after the next rising edge; inputs are changed here
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Quiet all master requests and bank responses, bank always ready
  task automatic applyIdle();
    m_req_i    = '0;
    m_add_i    = '0;
    m_wen_i    = '0;
    m_wdata_i  = '0;
    m_be_i     = '0;
    b_gnt_i    = 4'hF;
    b_rvalid_i = '0;
    b_rdata_i  = '0;
  endtask

  task automatic test_reset();
    applyIdle();
    rst_i   = 1'b1;
    m_req_i = 4'hF;
    m_add_i = {BASE + 32'hC, BASE + 32'h8, BASE + 32'h4, BASE};
    m_wen_i = 4'hF;
    tick();
    tick();
    b_rvalid_i = 4'hF;
    b_rdata_i  = {4{32'hFFFF_FFFF}};
    #2;
    checks++;
    if (m_gnt_o !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_gnt: got %h expected %h", m_gnt_o, 4'h0);
    end
    checks++;
    if (b_req_o !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_breq: got %h expected %h", b_req_o, 4'h0);
    end
    checks++;
    if (m_rvalid_o !== 4'h0 || m_rdata_o !== 128'h0) begin
      errors++;
      $display("[TB] FAIL reset_rvalid: got %h/%h expected 0/0", m_rvalid_o, m_rdata_o);
    end
    applyIdle();
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    applyIdle();
    m_req_i[0]        = 1'b1;
    m_add_i[31:0]     = BASE + 32'h14;
    m_wen_i[0]        = 1'b0;
    m_wdata_i[31:0]   = 32'hDEAD_BEEF;
    m_be_i[3:0]       = 4'hF;
    #2;
    checks++;
    if (b_req_o !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL write_breq: got %b expected %b", b_req_o, 4'b0010);
    end
    checks++;
    if (b_add_o[63:32] !== BASE + 32'h4) begin
      errors++;
      $display("[TB] FAIL write_badd: got %h expected %h", b_add_o[63:32], BASE + 32'h4);
    end
    checks++;
    if (b_wdata_o[63:32] !== 32'hDEAD_BEEF || b_wen_o[1] !== 1'b0 || b_be_o[7:4] !== 4'hF) begin
      errors++;
      $display("[TB] FAIL write_bdata: got %h/%b/%h expected deadbeef/0/f",
               b_wdata_o[63:32], b_wen_o[1], b_be_o[7:4]);
    end
    checks++;
    if (b_add_o[31:0] !== 32'h0 || b_wdata_o[31:0] !== 32'h0 || b_be_o[3:0] !== 4'h0) begin
      errors++;
      $display("[TB] FAIL write_idle_bank: got %h/%h/%h expected 0/0/0",
               b_add_o[31:0], b_wdata_o[31:0], b_be_o[3:0]);
    end
    checks++;
    if (m_gnt_o !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL write_gnt: got %b expected %b", m_gnt_o, 4'b0001);
    end
    tick();
    applyIdle();
    b_rvalid_i = 4'b0010;
    b_rdata_i[63:32] = 32'h1234_5678;
    #2;
    checks++;
    if (m_rvalid_o !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL write_rvalid: got %b expected %b", m_rvalid_o, 4'b0001);
    end
    tick();
    applyIdle();
  endtask

  task automatic test_back_to_back();
    // Cycle A: master i reads bank i
    applyIdle();
    m_req_i = 4'hF;
    m_wen_i = 4'hF;
    m_add_i = {BASE + 32'hC, BASE + 32'h8, BASE + 32'h4, BASE};
    #2;
    checks++;
    if (m_gnt_o !== 4'hF || b_req_o !== 4'hF) begin
      errors++;
      $display("[TB] FAIL par_gnt: got %h/%h expected f/f", m_gnt_o, b_req_o);
    end
    checks++;
    if (b_add_o !== {4{BASE}} || b_wen_o !== 4'hF) begin
      errors++;
      $display("[TB] FAIL par_badd: got %h/%h expected %h/f", b_add_o, b_wen_o, {4{BASE}});
    end
    tick();
    // Cycle B: master i reads bank 3-i in the next word row, responses of A return
    m_add_i    = {BASE + 32'h10, BASE + 32'h14, BASE + 32'h18, BASE + 32'h1C};
    b_rvalid_i = 4'hF;
    b_rdata_i  = {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0};
    #2;
    checks++;
    if (m_rvalid_o !== 4'hF) begin
      errors++;
      $display("[TB] FAIL par_rvalid: got %h expected f", m_rvalid_o);
    end
    checks++;
    if (m_rdata_o !== {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0}) begin
      errors++;
      $display("[TB] FAIL par_rdata: got %h expected d3../c2../b1../a0..", m_rdata_o);
    end
    checks++;
    if (m_gnt_o !== 4'hF || b_add_o !== {4{BASE + 32'h4}}) begin
      errors++;
      $display("[TB] FAIL b2b_gnt: got %h/%h expected f/%h", m_gnt_o, b_add_o, {4{BASE + 32'h4}});
    end
    tick();
    // Cycle C: crossed responses of B
    m_req_i    = '0;
    b_rvalid_i = 4'hF;
    b_rdata_i  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    #2;
    checks++;
    if (m_rvalid_o !== 4'hF || m_rdata_o !== {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444}) begin
      errors++;
      $display("[TB] FAIL b2b_rdata: got %h/%h expected f/11../22../33../44..", m_rvalid_o, m_rdata_o);
    end
    tick();
    applyIdle();
  endtask

  task automatic test_contention();
    logic [3:0]  expGnt [4];
    logic [31:0] expAdd [4];
`ifdef L2_XBAR_RR_ARB_EN
    expGnt = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
    expAdd = '{BASE, BASE + 32'h4, BASE, BASE + 32'h4};
`else
    expGnt = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
    expAdd = '{BASE, BASE, BASE, BASE};
`endif
    applyIdle();
    m_req_i = 4'b0110;
    m_wen_i = 4'hF;
    m_add_i = {32'h0, BASE + 32'h10, BASE, 32'h0};
    for (int c = 0; c < 4; c++) begin
      #2;
      checks++;
      if (m_gnt_o !== expGnt[c] || b_req_o !== 4'b0001) begin
        errors++;
        $display("[TB] FAIL contend_gnt[%0d]: got %b/%b expected %b/0001", c, m_gnt_o, b_req_o, expGnt[c]);
      end
      checks++;
      if (b_add_o[31:0] !== expAdd[c]) begin
        errors++;
        $display("[TB] FAIL contend_badd[%0d]: got %h expected %h", c, b_add_o[31:0], expAdd[c]);
      end
      tick();
    end
    applyIdle();
    tick();
  endtask

  task automatic test_bank_stall();
    applyIdle();
    m_req_i        = 4'b1000;
    m_wen_i        = 4'hF;
    m_add_i[127:96] = BASE + 32'h8;
    b_gnt_i        = 4'b1011;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin
        b_rvalid_i = 4'b0100;
        b_rdata_i[95:64] = 32'h5555_AAAA;
      end
      #2;
      checks++;
      if (m_gnt_o !== 4'h0 || b_req_o !== 4'b0100 || b_add_o[95:64] !== BASE) begin
        errors++;
        $display("[TB] FAIL stall_gnt[%0d]: got %b/%b/%h expected 0000/0100/%h",
                 c, m_gnt_o, b_req_o, b_add_o[95:64], BASE);
      end
      checks++;
      if (m_rvalid_o !== 4'h0) begin
        errors++;
        $display("[TB] FAIL stall_rvalid[%0d]: got %b expected 0000", c, m_rvalid_o);
      end
      tick();
    end
    b_gnt_i    = 4'hF;
    b_rvalid_i = '0;
    #2;
    checks++;
    if (m_gnt_o !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL stall_release_gnt: got %b expected 1000", m_gnt_o);
    end
    tick();
    m_req_i    = '0;
    b_rvalid_i = 4'b0100;
    b_rdata_i[95:64] = 32'hCAFE_F00D;
    #2;
    checks++;
    if (m_rvalid_o !== 4'b1000 || m_rdata_o[127:96] !== 32'hCAFE_F00D) begin
      errors++;
      $display("[TB] FAIL stall_resp: got %b/%h expected 1000/cafef00d", m_rvalid_o, m_rdata_o[127:96]);
    end
    tick();
    applyIdle();
  endtask

  task automatic test_reset_in_flight();
    applyIdle();
    m_req_i      = 4'b0010;
    m_wen_i      = 4'hF;
    m_add_i[63:32] = BASE;
    #2;
    checks++;
    if (m_gnt_o !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL rstfl_gnt: got %b expected 0010", m_gnt_o);
    end
    tick();
    m_req_i    = '0;
    rst_i      = 1'b1;
    b_rvalid_i = 4'b0001;
    b_rdata_i[31:0] = 32'h0BAD_0BAD;
    #2;
    checks++;
    if (m_rvalid_o !== 4'h0 || m_rdata_o !== 128'h0) begin
      errors++;
      $display("[TB] FAIL rstfl_rvalid: got %b/%h expected 0000/0", m_rvalid_o, m_rdata_o);
    end
    tick();
    rst_i = 1'b0;
    #2;
    checks++;
    if (m_rvalid_o !== 4'h0) begin
      errors++;
      $display("[TB] FAIL rstfl_after: got %b expected 0000", m_rvalid_o);
    end
    b_rvalid_i = '0;
    m_req_i    = 4'b0110;
    m_add_i    = {32'h0, BASE + 32'h10, BASE, 32'h0};
    #1;
    checks++;
    if (m_gnt_o !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL rstfl_ptr: got %b expected 0010", m_gnt_o);
    end
    tick();
    applyIdle();
    tick();
  endtask

  task automatic test_spurious();
    applyIdle();
    b_rvalid_i = 4'b1000;
    b_rdata_i[127:96] = 32'hFEED_FACE;
    #2;
    checks++;
    if (m_rvalid_o !== 4'h0 || m_rdata_o !== 128'h0) begin
      errors++;
      $display("[TB] FAIL spurious: got %b/%h expected 0000/0", m_rvalid_o, m_rdata_o);
    end
    tick();
    applyIdle();
  endtask

  // Scenario sequence
  initial begin
    rst_i = 1'b1;
    applyIdle();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_contention();
    test_bank_stall();
    test_reset_in_flight();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
